// File: rtl/stage_fetch_decoupled_pkg.sv
// Shared types for the decoupled fetch stage: cache lane data, predictor request/response,
// fetch-queue entries and the fetch FSM state.
package stage_fetch_decoupled_pkg;

  localparam int ADDR_W       = 32;
  localparam int INST_W       = 32;
  localparam int CACHE_LINE_W = 32;
  localparam int GHR_W        = 8;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic {
    FS_RUN,
    FS_MISS
  } FETCH_STATE;

  typedef struct packed {
    logic                    valid;
    logic [CACHE_LINE_W-1:0] cache_line;
  } CACHE_DATA;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] pc;
    logic              used;
  } BP_PREDICT_REQUEST;

  typedef struct packed {
    logic              taken;
    logic [ADDR_W-1:0] target;
    logic [GHR_W-1:0]  ghr_snapshot;
  } BP_PREDICT_RESPONSE;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
    logic              is_branch;
    logic              bp_taken;
    logic [ADDR_W-1:0] bp_target;
    logic [GHR_W-1:0]  bp_ghr;
  } FETCH_ENTRY;

  localparam int CACHE_W   = $bits(CACHE_DATA);
  localparam int BP_REQ_W  = $bits(BP_PREDICT_REQUEST);
  localparam int BP_RESP_W = $bits(BP_PREDICT_RESPONSE);
  localparam int FE_W      = $bits(FETCH_ENTRY);

  function automatic logic isBranchOpcode(input logic [6:0] opcode);
    return opcode == OPC_BRANCH;
  endfunction

endpackage

// File: rtl/stage_fetch_decoupled_queue.sv
// Circular FIFO of fetch bundles with a flush that empties it in one cycle.
// Pointers wrap naturally because DEPTH is a power of two.
module fetch_queue #(
  parameter type T     = logic,
  parameter int  DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush_i,
  input  logic                   enq_i,
  input  T                       data_i,
  input  logic                   deq_i,
  output T                       head_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  T                 mem_q [DEPTH];
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [CNT_W-1:0] count_q;

  logic doEnq;
  logic doDeq;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[head_q];

  assign doDeq = deq_i && !empty_o;
  assign doEnq = enq_i && (!full_o || doDeq);

  // Flush wins over any same-cycle enqueue or dequeue.
  always_ff @(posedge clock) begin
    if (reset || flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (doEnq) tail_q <= tail_q + PTR_W'(1);
      if (doDeq) head_q <= head_q + PTR_W'(1);
      case ({doEnq, doDeq})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (doEnq && !flush_i && !reset) mem_q[tail_q] <= data_i;
  end

endmodule

// File: rtl/stage_fetch_decoupled.sv
// N-lane fetch front end: lane scan, bundle truncation at the first predicted-taken branch,
// PC/FSM control and a fetch queue decoupling the icache from instruction-buffer backpressure.
module stage_fetch_decoupled
  import stage_fetch_decoupled_pkg::*;
#(
  parameter int          N        = 2,
  parameter int          FQ_DEPTH = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic [N*ADDR_W-1:0]   icache_read_addr_o,
  input  logic [N*CACHE_W-1:0]  icache_cache_out_i,
  output logic [BP_REQ_W-1:0]   bp_predict_req_o,
  input  logic [BP_RESP_W-1:0]  bp_predict_resp_i,
  input  logic                  ib_ready_i,
  output logic                  ib_valid_o,
  output logic [N*FE_W-1:0]     ib_fetch_o,
  output logic [N-1:0]          ib_lane_valid_o,
  input  logic                  redirect_valid_i,
  input  logic [ADDR_W-1:0]     redirect_pc_i,
  input  logic                  fetch_enable_i,
  output logic                  fetch_stall_o,
  output logic [31:0]           miss_cycles_o,
  output logic [ADDR_W-1:0]     pc_debug_o
);

  localparam int LANE_W = (N > 1) ? $clog2(N) : 1;
  localparam int CNT_W  = $clog2(FQ_DEPTH) + 1;

  typedef struct packed {
    FETCH_ENTRY [N-1:0] entries;
    logic [N-1:0]       lane_valid;
  } FETCH_BUNDLE;

  FETCH_STATE         state_q;
  logic [ADDR_W-1:0]  pc_q;
  logic [ADDR_W-1:0]  pc_d;
  logic [31:0]        missCycles_q;

  CACHE_DATA          lanes [N];
  BP_PREDICT_RESPONSE bpResp;
  BP_PREDICT_REQUEST  bpReq;
  FETCH_BUNDLE        newBundle;
  FETCH_BUNDLE        headBundle;

  logic              found;
  logic [LANE_W-1:0] firstBr;
  logic [LANE_W-1:0] cut;
  logic              predTaken;
  logic              bundleReady;
  logic              hasSpace;
  logic              enq;
  logic              deq;
  logic              qFull;
  logic              qEmpty;
  logic [CNT_W-1:0]  qCount;

  assign bpResp = bp_predict_resp_i;

  // Scan lanes for the lowest valid branch and decide how much of the bundle is needed.
  always_comb begin
    found       = 1'b0;
    firstBr     = '0;
    bundleReady = 1'b1;
    for (int i = 0; i < N; i++) begin
      lanes[i] = icache_cache_out_i[i*CACHE_W +: CACHE_W];
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (lanes[i].valid && isBranchOpcode(lanes[i].cache_line[6:0])) begin
        found   = 1'b1;
        firstBr = LANE_W'(i);
      end
    end
    predTaken = found && bpResp.taken;
    cut       = predTaken ? firstBr : LANE_W'(N - 1);
    for (int i = 0; i < N; i++) begin
      if (i <= int'(cut) && !lanes[i].valid) bundleReady = 1'b0;
    end
  end

  assign deq      = ib_valid_o && ib_ready_i;
  assign hasSpace = (int'(qCount) < FQ_DEPTH) || deq;
  assign enq      = (state_q == FS_RUN) && fetch_enable_i && bundleReady
                    && !redirect_valid_i && hasSpace;

  // Lanes past the cut are left fully zeroed with their valid bit clear.
  always_comb begin
    newBundle          = '0;
    icache_read_addr_o = '0;
    for (int i = 0; i < N; i++) begin
      icache_read_addr_o[i*ADDR_W +: ADDR_W] = pc_q + ADDR_W'(4 * i);
      if (i <= int'(cut)) begin
        newBundle.lane_valid[i]   = 1'b1;
        newBundle.entries[i].pc   = pc_q + ADDR_W'(4 * i);
        newBundle.entries[i].inst = lanes[i].cache_line[INST_W-1:0];
        if (found && i == int'(firstBr)) begin
          newBundle.entries[i].is_branch = 1'b1;
          newBundle.entries[i].bp_taken  = bpResp.taken;
          newBundle.entries[i].bp_target = bpResp.target;
          newBundle.entries[i].bp_ghr    = bpResp.ghr_snapshot;
        end
      end
    end
  end

  always_comb begin
    bpReq.valid = fetch_enable_i && found;
    bpReq.pc    = pc_q + ADDR_W'(4 * int'(firstBr));
    bpReq.used  = enq && found;
  end

  assign bp_predict_req_o = bpReq;

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid_i)   pc_d = redirect_pc_i;
    else if (enq && predTaken) pc_d = bpResp.target;
    else if (enq)           pc_d = pc_q + ADDR_W'(4 * N);
  end

  // PC, fetch FSM and miss counter; a redirect always returns the FSM to RUN.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q         <= RESET_PC;
      state_q      <= FS_RUN;
      missCycles_q <= '0;
    end else begin
      pc_q <= pc_d;
      case (state_q)
        FS_RUN: begin
          if (!redirect_valid_i && fetch_enable_i && !bundleReady && hasSpace)
            state_q <= FS_MISS;
        end
        FS_MISS: begin
          if (missCycles_q != 32'hFFFF_FFFF) missCycles_q <= missCycles_q + 32'd1;
          if (redirect_valid_i || (fetch_enable_i && bundleReady)) state_q <= FS_RUN;
        end
        default: state_q <= FS_RUN;
      endcase
    end
  end

  fetch_queue #(
    .T     (FETCH_BUNDLE),
    .DEPTH (FQ_DEPTH)
  ) uQueue (
    .clock   (clock),
    .reset   (reset),
    .flush_i (redirect_valid_i),
    .enq_i   (enq),
    .data_i  (newBundle),
    .deq_i   (deq),
    .head_o  (headBundle),
    .full_o  (qFull),
    .empty_o (qEmpty),
    .count_o (qCount)
  );

  assign ib_valid_o      = !qEmpty;
  assign ib_fetch_o      = qEmpty ? '0 : headBundle.entries;
  assign ib_lane_valid_o = qEmpty ? '0 : headBundle.lane_valid;
  assign fetch_stall_o   = (state_q == FS_MISS) || (qFull && !deq);
  assign miss_cycles_o   = missCycles_q;
  assign pc_debug_o      = pc_q;

endmodule

// File: tb/tb_stage_fetch_decoupled.sv
// Directed bench for stage_fetch_decoupled (N=2, FQ_DEPTH=4): a vector table for bundle
// formation plus hand sequences for miss, full-queue, redirect and mid-miss reset.
module tb_stage_fetch_decoupled;
  import stage_fetch_decoupled_pkg::*;

  localparam int N     = 2;
  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] BR  = 32'h0000_0063;

  logic                  clock = 1'b0;
  logic                  reset = 1'b1;
  logic [N*ADDR_W-1:0]   icache_read_addr_o;
  logic [N*CACHE_W-1:0]  icache_cache_out_i = '0;
  logic [BP_REQ_W-1:0]   bp_predict_req_o;
  logic [BP_RESP_W-1:0]  bp_predict_resp_i = '0;
  logic                  ib_ready_i = 1'b1;
  logic                  ib_valid_o;
  logic [N*FE_W-1:0]     ib_fetch_o;
  logic [N-1:0]          ib_lane_valid_o;
  logic                  redirect_valid_i = 1'b0;
  logic [ADDR_W-1:0]     redirect_pc_i = '0;
  logic                  fetch_enable_i = 1'b1;
  logic                  fetch_stall_o;
  logic [31:0]           miss_cycles_o;
  logic [ADDR_W-1:0]     pc_debug_o;

  stage_fetch_decoupled #(.N(N), .FQ_DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clock              (clock),
    .reset              (reset),
    .icache_read_addr_o (icache_read_addr_o),
    .icache_cache_out_i (icache_cache_out_i),
    .bp_predict_req_o   (bp_predict_req_o),
    .bp_predict_resp_i  (bp_predict_resp_i),
    .ib_ready_i         (ib_ready_i),
    .ib_valid_o         (ib_valid_o),
    .ib_fetch_o         (ib_fetch_o),
    .ib_lane_valid_o    (ib_lane_valid_o),
    .redirect_valid_i   (redirect_valid_i),
    .redirect_pc_i      (redirect_pc_i),
    .fetch_enable_i     (fetch_enable_i),
    .fetch_stall_o      (fetch_stall_o),
    .miss_cycles_o      (miss_cycles_o),
    .pc_debug_o         (pc_debug_o)
  );

  always #5 clock = ~clock;

  BP_PREDICT_REQUEST bpReq;
  FETCH_ENTRY        head0;
  FETCH_ENTRY        head1;
  assign bpReq = bp_predict_req_o;
  assign head0 = ib_fetch_o[0 +: FE_W];
  assign head1 = ib_fetch_o[FE_W +: FE_W];

  int checkCount = 0;
  int errorCount = 0;

  typedef struct {
    logic        v0, v1;
    logic [31:0] i0, i1;
    logic        tk;
    logic [31:0] tgt;
    logic [7:0]  ghr;
    logic        expBpValid;
    logic [31:0] expBpPc;
    logic        expUsed;
    logic [1:0]  expMask;
    logic [31:0] expPc0, expPc1;
    logic [1:0]  expBr, expTk;
    logic [31:0] expTgt0, expTgt1;
    logic [15:0] expGhr;
    logic [31:0] expNextPc;
  } VectorRec;

  VectorRec vecs [8];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v0, input logic v1, input logic [31:0] i0,
                               input logic [31:0] i1, input logic tk, input logic [31:0] tgt,
                               input logic [7:0] ghr);
    icache_cache_out_i = {v1, i1, v0, i0};
    bp_predict_resp_i  = {tk, tgt, ghr};
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic doReset();
    reset            = 1'b1;
    ib_ready_i       = 1'b1;
    fetch_enable_i   = 1'b1;
    redirect_valid_i = 1'b0;
    redirect_pc_i    = '0;
    applyStimulus(1'b1, 1'b1, NOP, NOP, 1'b0, 32'h0, 8'h0);
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] pcCur;

    //        v0 v1 i0   i1   tk  tgt          ghr    bpV bpPc         used mask  pc0          pc1          br     tk     tgt0         tgt1         ghr         next
    vecs[0] = '{1, 1, NOP, NOP, 0, 32'h0,       8'h00, 0, 32'h0,       0, 2'b11, 32'h00,      32'h04,      2'b00, 2'b00, 32'h0,       32'h0,       16'h0000, 32'h08};
    vecs[1] = '{1, 1, NOP, NOP, 0, 32'h0,       8'h00, 0, 32'h0,       0, 2'b11, 32'h08,      32'h0C,      2'b00, 2'b00, 32'h0,       32'h0,       16'h0000, 32'h10};
    vecs[2] = '{1, 1, BR,  NOP, 1, 32'h40,      8'hA5, 1, 32'h10,      1, 2'b01, 32'h10,      32'h00,      2'b01, 2'b01, 32'h40,      32'h0,       16'h00A5, 32'h40};
    vecs[3] = '{1, 1, NOP, BR,  1, 32'h80,      8'h3C, 1, 32'h44,      1, 2'b11, 32'h40,      32'h44,      2'b10, 2'b10, 32'h0,       32'h80,      16'h3C00, 32'h80};
    vecs[4] = '{1, 1, NOP, BR,  0, 32'h999,     8'h11, 1, 32'h84,      1, 2'b11, 32'h80,      32'h84,      2'b10, 2'b00, 32'h0,       32'h999,     16'h1100, 32'h88};
    vecs[5] = '{1, 1, BR,  BR,  0, 32'h300,     8'h22, 1, 32'h88,      1, 2'b11, 32'h88,      32'h8C,      2'b01, 2'b00, 32'h300,     32'h0,       16'h0022, 32'h90};
    vecs[6] = '{1, 1, NOP, NOP, 1, 32'h500,     8'h77, 0, 32'h0,       0, 2'b11, 32'h90,      32'h94,      2'b00, 2'b00, 32'h0,       32'h0,       16'h0000, 32'h98};
    vecs[7] = '{1, 0, BR,  NOP, 1, 32'h10,      8'h5A, 1, 32'h98,      1, 2'b01, 32'h98,      32'h00,      2'b01, 2'b01, 32'h10,      32'h0,       16'h005A, 32'h10};

    doReset();
    checkOutput("reset.pc", pc_debug_o, 32'h0);
    checkOutput("reset.ibValid", ib_valid_o, 1'b0);
    checkOutput("reset.laneValid", ib_lane_valid_o, 2'b00);
    checkOutput("reset.stall", fetch_stall_o, 1'b0);
    checkOutput("reset.miss", miss_cycles_o, 32'h0);

    pcCur = 32'h0;
    for (int k = 0; k < 8; k++) begin
      applyStimulus(vecs[k].v0, vecs[k].v1, vecs[k].i0, vecs[k].i1, vecs[k].tk, vecs[k].tgt, vecs[k].ghr);
      #1;
      checkOutput($sformatf("vec%0d.addr", k), icache_read_addr_o, {pcCur + 32'd4, pcCur});
      checkOutput($sformatf("vec%0d.bpValid", k), bpReq.valid, vecs[k].expBpValid);
      if (vecs[k].expBpValid) checkOutput($sformatf("vec%0d.bpPc", k), bpReq.pc, vecs[k].expBpPc);
      checkOutput($sformatf("vec%0d.bpUsed", k), bpReq.used, vecs[k].expUsed);
      step();
      checkOutput($sformatf("vec%0d.ibValid", k), ib_valid_o, 1'b1);
      checkOutput($sformatf("vec%0d.mask", k), ib_lane_valid_o, vecs[k].expMask);
      checkOutput($sformatf("vec%0d.pc0", k), head0.pc, vecs[k].expPc0);
      checkOutput($sformatf("vec%0d.pc1", k), head1.pc, vecs[k].expPc1);
      checkOutput($sformatf("vec%0d.isBranch", k), {head1.is_branch, head0.is_branch}, vecs[k].expBr);
      checkOutput($sformatf("vec%0d.bpTaken", k), {head1.bp_taken, head0.bp_taken}, vecs[k].expTk);
      checkOutput($sformatf("vec%0d.tgt0", k), head0.bp_target, vecs[k].expTgt0);
      checkOutput($sformatf("vec%0d.tgt1", k), head1.bp_target, vecs[k].expTgt1);
      checkOutput($sformatf("vec%0d.ghr", k), {head1.bp_ghr, head0.bp_ghr}, vecs[k].expGhr);
      checkOutput($sformatf("vec%0d.nextPc", k), pc_debug_o, vecs[k].expNextPc);
      pcCur = vecs[k].expNextPc;
    end

    // Miss at 0x20 for three cycles with lane1 invalid.
    doReset();
    for (int k = 0; k < 4; k++) step();
    checkOutput("miss.startPc", pc_debug_o, 32'h20);
    applyStimulus(1'b1, 1'b0, NOP, NOP, 1'b0, 32'h0, 8'h0);
    #1;
    checkOutput("miss.noUsed", bpReq.used, 1'b0);
    step();
    checkOutput("miss.stall1", fetch_stall_o, 1'b1);
    checkOutput("miss.drained", ib_valid_o, 1'b0);
    checkOutput("miss.miss1", miss_cycles_o, 32'd0);
    step();
    step();
    checkOutput("miss.miss3", miss_cycles_o, 32'd2);
    checkOutput("miss.stall3", fetch_stall_o, 1'b1);
    applyStimulus(1'b1, 1'b1, NOP, NOP, 1'b0, 32'h0, 8'h0);
    step();
    checkOutput("miss.count", miss_cycles_o, 32'd3);
    checkOutput("miss.stallOff", fetch_stall_o, 1'b0);
    checkOutput("miss.pcHeld", pc_debug_o, 32'h20);
    checkOutput("miss.noEnq", ib_valid_o, 1'b0);
    step();
    checkOutput("miss.enqValid", ib_valid_o, 1'b1);
    checkOutput("miss.enqPc", head0.pc, 32'h20);
    checkOutput("miss.nextPc", pc_debug_o, 32'h28);

    // Backpressure fills the queue, then simultaneous enqueue/dequeue at full.
    doReset();
    ib_ready_i = 1'b0;
    for (int k = 0; k < 4; k++) step();
    #1;
    checkOutput("full.stall5", fetch_stall_o, 1'b1);
    step();
    step();
    checkOutput("full.pcHeld", pc_debug_o, 32'h20);
    checkOutput("full.head", head0.pc, 32'h0);
    checkOutput("full.stall6", fetch_stall_o, 1'b1);
    ib_ready_i = 1'b1;
    #1;
    checkOutput("full.stallDeq", fetch_stall_o, 1'b0);
    step();
    checkOutput("full.pcAdv", pc_debug_o, 32'h28);
    checkOutput("full.headAdv", head0.pc, 32'h8);
    fetch_enable_i = 1'b0;
    step();
    checkOutput("drain.h1", head0.pc, 32'h10);
    step();
    checkOutput("drain.h2", head0.pc, 32'h18);
    step();
    checkOutput("drain.h3", head0.pc, 32'h20);
    checkOutput("drain.valid3", ib_valid_o, 1'b1);
    step();
    checkOutput("drain.empty", ib_valid_o, 1'b0);
    checkOutput("drain.pcHold", pc_debug_o, 32'h28);

    // Redirect with three entries queued.
    doReset();
    ib_ready_i = 1'b0;
    for (int k = 0; k < 3; k++) step();
    applyStimulus(1'b1, 1'b1, BR, NOP, 1'b0, 32'h0, 8'h0);
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 32'h100;
    #1;
    checkOutput("redir.bpValid", bpReq.valid, 1'b1);
    checkOutput("redir.bpUsed", bpReq.used, 1'b0);
    step();
    redirect_valid_i = 1'b0;
    checkOutput("redir.ibValid", ib_valid_o, 1'b0);
    checkOutput("redir.pc", pc_debug_o, 32'h100);
    checkOutput("redir.laneValid", ib_lane_valid_o, 2'b00);
    applyStimulus(1'b1, 1'b1, NOP, NOP, 1'b0, 32'h0, 8'h0);
    step();
    checkOutput("redir.newHead", head0.pc, 32'h100);
    checkOutput("redir.newPc", pc_debug_o, 32'h108);

    // Reset asserted while in MISS with two entries queued.
    doReset();
    ib_ready_i = 1'b0;
    step();
    step();
    applyStimulus(1'b1, 1'b0, NOP, NOP, 1'b0, 32'h0, 8'h0);
    step();
    step();
    step();
    checkOutput("rstMiss.miss", miss_cycles_o, 32'd2);
    checkOutput("rstMiss.qValid", ib_valid_o, 1'b1);
    reset = 1'b1;
    step();
    checkOutput("rstMiss.pc", pc_debug_o, 32'h0);
    checkOutput("rstMiss.ibValid", ib_valid_o, 1'b0);
    checkOutput("rstMiss.laneValid", ib_lane_valid_o, 2'b00);
    checkOutput("rstMiss.stall", fetch_stall_o, 1'b0);
    checkOutput("rstMiss.missCnt", miss_cycles_o, 32'd0);
    reset      = 1'b0;
    ib_ready_i = 1'b1;
    applyStimulus(1'b1, 1'b1, NOP, NOP, 1'b0, 32'h0, 8'h0);
    step();
    checkOutput("rstMiss.runEnq", ib_valid_o, 1'b1);
    checkOutput("rstMiss.runHead", head0.pc, 32'h0);
    checkOutput("rstMiss.runPc", pc_debug_o, 32'h8);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
